// File: rtl/bep_rx_pkg.sv
// Shared types and constants for the BEP serial receiver front end.
// The optional parity path (macro BEP_RX_PARITY_EN) uses odd_parity() below.
package bep_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } rx_state_t;

    localparam int DEFAULT_DATA_W      = 8;
    localparam int DEFAULT_FIFO_DEPTH  = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int MAX_DATA_W          = 16;

    // Odd-parity bit for a word; narrower words are zero-extended, which
    // leaves the population count unchanged.
    function automatic logic odd_parity(input logic [MAX_DATA_W-1:0] word);
        return ~(^word);
    endfunction

endpackage

// File: rtl/bep_rx_fifo.sv
// Small synchronous FIFO carrying {first, data}; pointers are one bit wider
// than the address so full/empty fall out of a pointer comparison.
module bep_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop frees the slot on a full FIFO; a pop on an empty FIFO never happens.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/bep_serial_rx.sv
// Serial-to-word receiver ahead of the BEP decoder: synchronise, deserialise
// MSB-first, queue in a FIFO. Define BEP_RX_PARITY_EN for a per-word odd-parity bit.
module bep_serial_rx
    import bep_rx_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ser_clk_i,
    input  logic                          ser_data_i,
    input  logic                          ser_frame_i,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_first,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
`ifdef BEP_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic                          frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Bit order of the synchroniser bank: 0 = ser_clk, 1 = ser_data, 2 = ser_frame.
    logic [2:0] pin_async;
    logic [2:0] pin_sync;

    assign pin_async = {ser_frame_i, ser_data_i, ser_clk_i};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_async[gi]};
                end
            end
            assign pin_sync[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic sclk_dly_reg;
    logic frame_dly_reg;
    logic sclk_rise;
    logic frame_rise;
    logic frame_fall;
    logic data_bit;

    assign sclk_rise  = pin_sync[0] && !sclk_dly_reg;
    assign data_bit   = pin_sync[1];
    assign frame_rise = pin_sync[2] && !frame_dly_reg;
    assign frame_fall = !pin_sync[2] && frame_dly_reg;

    rx_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [DATA_W-1:0] shifted;
    logic              first_pending_reg, first_pending_next;
    logic              frame_err_reg, frame_err_next;
    logic              overflow_reg, overflow_next;
`ifdef BEP_RX_PARITY_EN
    logic              parity_err_reg, parity_err_next;
`endif

    logic              fifo_push;
    logic [DATA_W-1:0] push_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;

    assign shifted = {shift_reg[DATA_W-2:0], data_bit};

    always_comb begin
        state_next         = state_reg;
        bit_cnt_next       = bit_cnt_reg;
        shift_next         = shift_reg;
        first_pending_next = first_pending_reg;
        frame_err_next     = 1'b0;
        fifo_push          = 1'b0;
        push_word          = shifted;
`ifdef BEP_RX_PARITY_EN
        parity_err_next    = parity_err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (frame_rise) begin
                    state_next         = SHIFT;
                    bit_cnt_next       = '0;
                    first_pending_next = 1'b1;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shift_next = shifted;
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_next = '0;
`ifdef BEP_RX_PARITY_EN
                        state_next = PARITY;
`else
                        fifo_push          = 1'b1;
                        first_pending_next = 1'b0;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
                // The bit arriving with the frame fall is counted first, so a
                // word completed on that edge is not reported as partial.
                if (frame_fall) begin
                    frame_err_next = (bit_cnt_next != '0) || (state_next == PARITY);
                    state_next     = IDLE;
                end
            end
`ifdef BEP_RX_PARITY_EN
            PARITY: begin
                if (sclk_rise) begin
                    state_next = SHIFT;
                    if (data_bit == odd_parity(MAX_DATA_W'(shift_reg))) begin
                        fifo_push          = 1'b1;
                        push_word          = shift_reg;
                        first_pending_next = 1'b0;
                    end else begin
                        parity_err_next = 1'b1;
                    end
                end
                if (frame_fall) begin
                    frame_err_next = !sclk_rise;
                    state_next     = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // When full, out_valid is high, so the pop in this cycle is exactly out_ready.
    assign overflow_next = overflow_reg || (fifo_push && fifo_full && !out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            bit_cnt_reg       <= '0;
            shift_reg         <= '0;
            first_pending_reg <= 1'b0;
            frame_err_reg     <= 1'b0;
            overflow_reg      <= 1'b0;
            sclk_dly_reg      <= 1'b0;
            frame_dly_reg     <= 1'b0;
`ifdef BEP_RX_PARITY_EN
            parity_err_reg    <= 1'b0;
`endif
        end else begin
            state_reg         <= state_next;
            bit_cnt_reg       <= bit_cnt_next;
            shift_reg         <= shift_next;
            first_pending_reg <= first_pending_next;
            frame_err_reg     <= frame_err_next;
            overflow_reg      <= overflow_next;
            sclk_dly_reg      <= pin_sync[0];
            frame_dly_reg     <= pin_sync[2];
`ifdef BEP_RX_PARITY_EN
            parity_err_reg    <= parity_err_next;
`endif
        end
    end

    bep_rx_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({first_pending_reg, push_word}),
        .pop       (out_ready),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_valid = !fifo_empty;
    assign out_first = fifo_head[DATA_W];
    assign out_data  = fifo_head[DATA_W-1:0];
    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;
`ifdef BEP_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_bep_serial_rx.sv
// Randomised self-checking bench for bep_serial_rx against a word-level model
// that packs each frame's bit list into words.
module tb_bep_serial_rx;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int HALF  = 4;
`ifdef BEP_RX_PARITY_EN
    localparam int UNIT  = W + 1;
`else
    localparam int UNIT  = W;
`endif

    logic         clk;
    logic         rst;
    logic         ser_clk_i;
    logic         ser_data_i;
    logic         ser_frame_i;
    logic [W-1:0] out_data;
    logic         out_first;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   fifo_level;
    logic         overflow;
    logic         frame_err;
`ifdef BEP_RX_PARITY_EN
    logic         parity_err;
`endif

    bep_serial_rx #(
        .DATA_W      (W),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ser_clk_i   (ser_clk_i),
        .ser_data_i  (ser_data_i),
        .ser_frame_i (ser_frame_i),
        .out_data    (out_data),
        .out_first   (out_first),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
`ifdef BEP_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       fe_cycles = 0;
    int       exp_fe = 0;
    logic [W:0] rcv_q[$];
    logic [W:0] exp_q[$];
    bit       frame_bits[$];

    // Record every accepted word and every cycle frame_err is high.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            rcv_q.push_back({out_first, out_data});
        end
        if (frame_err) begin
            fe_cycles++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_word(input logic [W-1:0] d, input bit good);
        for (int i = W - 1; i >= 0; i--) begin
            frame_bits.push_back(d[i]);
        end
`ifdef BEP_RX_PARITY_EN
        frame_bits.push_back(good ? ~(^d) : (^d));
`else
        if (!good) begin
            frame_bits.push_back(1'b0);
        end
`endif
    endtask

    task automatic send_bit(input bit b);
        ser_data_i = b;
        tick(HALF);
        ser_clk_i = 1'b1;
        tick(HALF);
        ser_clk_i = 1'b0;
    endtask

    task automatic send_frame();
        ser_frame_i = 1'b1;
        tick(HALF);
        foreach (frame_bits[i]) send_bit(frame_bits[i]);
        tick(HALF);
        ser_frame_i = 1'b0;
        tick(2 * HALF);
    endtask

    // Word-level reference: every UNIT bits form one word (plus parity when
    // enabled); only the first accepted-parity word of a frame is marked first;
    // at most 'limit' words fit, the rest are dropped.
    task automatic model_frame(input int limit, output int dropped);
        int  n;
        int  v;
        int  accepted;
        bit  first;
        bit  good;
        n        = frame_bits.size();
        accepted = 0;
        dropped  = 0;
        first    = 1'b1;
        for (int u = 0; u < n / UNIT; u++) begin
            v = 0;
            for (int k = 0; k < W; k++) begin
                v = v * 2 + int'(frame_bits[u * UNIT + k]);
            end
            good = 1'b1;
`ifdef BEP_RX_PARITY_EN
            good = (($countones(v) + int'(frame_bits[u * UNIT + W])) % 2) == 1;
`endif
            if (good) begin
                if (accepted < limit) begin
                    exp_q.push_back({first, W'(v)});
                    accepted++;
                end else begin
                    dropped++;
                end
                first = 1'b0;
            end
        end
        if (n % UNIT != 0) begin
            exp_fe++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ser_clk_i = 1'b0; ser_data_i = 1'b0; ser_frame_i = 1'b0; out_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
        checks++; if (out_first !== 1'b0) begin errors++; $display("FAIL reset_first got %0b want 0", out_first); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %0b want 0", frame_err); end
`ifdef BEP_RX_PARITY_EN
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %0b want 0", parity_err); end
`endif
        $display("reset: valid=%0b level=%0d overflow=%0b", out_valid, fifo_level, overflow);
    endtask

    task automatic test_single();
        int dropped;
        out_ready = 1'b1;
        frame_bits.delete();
        add_word(8'hA5, 1'b1);
        model_frame(1000, dropped);
        send_frame();
        for (int i = 0; i < 400 && out_valid; i++) tick(1);
        checks++; if (rcv_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", rcv_q.size()); end
        checks++; if (rcv_q.size() > 0 && rcv_q[0] !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL single_word got %h want %h", rcv_q[0], {1'b1, 8'hA5});
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow got %0b want 0", overflow); end
        checks++; if (fe_cycles !== exp_fe) begin errors++; $display("FAIL single_frame_err got %0d want %0d", fe_cycles, exp_fe); end
        $display("single: received %0d word(s)", rcv_q.size());
        rcv_q.delete(); exp_q.delete();
    endtask

    task automatic test_three_words();
        int dropped;
        out_ready = 1'b1;
        frame_bits.delete();
        add_word(8'h12, 1'b1); add_word(8'h34, 1'b1); add_word(8'h56, 1'b1);
        model_frame(1000, dropped);
        send_frame();
        for (int i = 0; i < 400 && out_valid; i++) tick(1);
        checks++; if (rcv_q.size() !== exp_q.size()) begin errors++; $display("FAIL three_count got %0d want %0d", rcv_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL three_word%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL three_level got %0d want 0", fifo_level); end
        $display("three_words: received %0d word(s) level=%0d", rcv_q.size(), fifo_level);
        rcv_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_frames();
        int dropped;
        int nbits;
        out_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            frame_bits.delete();
            nbits = $urandom_range(3 * UNIT, 1);
            for (int b = 0; b < nbits; b++) frame_bits.push_back(bit'($urandom_range(1, 0)));
            model_frame(1000, dropped);
            send_frame();
            for (int i = 0; i < 400 && out_valid; i++) tick(1);
            $display("random_frame %0d: %0d bits, expected words so far %0d", f, nbits, exp_q.size());
        end
        checks++; if (rcv_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count got %0d want %0d", rcv_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_word%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
        end
        checks++; if (fe_cycles !== exp_fe) begin errors++; $display("FAIL random_frame_err got %0d want %0d", fe_cycles, exp_fe); end
        rcv_q.delete(); exp_q.delete();
    endtask

    task automatic test_frame_err();
        int dropped;
        out_ready = 1'b1;
        frame_bits.delete();
        for (int b = 0; b < 3; b++) frame_bits.push_back(bit'($urandom_range(1, 0)));
        model_frame(1000, dropped);
        send_frame();
        checks++; if (fe_cycles !== exp_fe) begin errors++; $display("FAIL partial_frame_err got %0d want %0d", fe_cycles, exp_fe); end
        checks++; if (rcv_q.size() !== 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL partial_push got %0d words valid=%0b want 0", rcv_q.size(), out_valid);
        end
        frame_bits.delete();
        add_word(W'($urandom), 1'b1);
        model_frame(1000, dropped);
        send_frame();
        for (int i = 0; i < 400 && out_valid; i++) tick(1);
        checks++; if (rcv_q.size() !== 1) begin errors++; $display("FAIL after_err_count got %0d want 1", rcv_q.size()); end
        checks++; if (rcv_q.size() > 0 && rcv_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL after_err_word got %h want %h", rcv_q[0], exp_q[0]);
        end
        $display("frame_err: pulses=%0d words=%0d", fe_cycles, rcv_q.size());
        rcv_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        int dropped;
        out_ready = 1'b0;
        frame_bits.delete();
        for (int k = 0; k < DEPTH + 1; k++) add_word(W'($urandom), 1'b1);
        model_frame(DEPTH, dropped);
        send_frame();
        checks++; if (fifo_level !== 3'(DEPTH)) begin errors++; $display("FAIL overflow_level got %0d want %0d", fifo_level, DEPTH); end
        checks++; if (overflow !== (dropped > 0)) begin errors++; $display("FAIL overflow_flag got %0b want %0b", overflow, dropped > 0); end
        out_ready = 1'b1;
        for (int i = 0; i < 400 && out_valid; i++) tick(1);
        out_ready = 1'b0;
        checks++; if (rcv_q.size() !== exp_q.size()) begin errors++; $display("FAIL overflow_count got %0d want %0d", rcv_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL overflow_word%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %0b want 1", overflow); end
        $display("overflow: dropped=%0d drained=%0d", dropped, rcv_q.size());
        rcv_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int dropped;
        int fe_before;
        out_ready = 1'b0;
        frame_bits.delete();
        add_word(W'($urandom), 1'b1); add_word(W'($urandom), 1'b1);
        for (int b = 0; b < 3; b++) frame_bits.push_back(bit'($urandom_range(1, 0)));
        ser_frame_i = 1'b1;
        tick(HALF);
        foreach (frame_bits[i]) send_bit(frame_bits[i]);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", out_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL midrst_level got %0d want 0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %0b want 0", overflow); end
        fe_before = fe_cycles;
        tick(HALF);
        ser_frame_i = 1'b0;
        tick(2 * HALF);
        checks++; if (fe_cycles !== fe_before) begin errors++; $display("FAIL midrst_frame_err got %0d want %0d", fe_cycles, fe_before); end
        rcv_q.delete();
        out_ready = 1'b1;
        frame_bits.delete();
        add_word(W'($urandom), 1'b1); add_word(W'($urandom), 1'b1);
        model_frame(1000, dropped);
        send_frame();
        for (int i = 0; i < 400 && out_valid; i++) tick(1);
        checks++; if (rcv_q.size() !== exp_q.size()) begin errors++; $display("FAIL midrst_count got %0d want %0d", rcv_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_word%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
        end
        $display("reset_mid: clean frame words=%0d", rcv_q.size());
        rcv_q.delete(); exp_q.delete();
    endtask

    task automatic test_full_pop();
        int dropped;
        int n;
        rst = 1'b1; out_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        frame_bits.delete();
        for (int k = 0; k < DEPTH + 1; k++) add_word(W'($urandom), 1'b1);
        model_frame(1000, dropped);
        n = frame_bits.size();
        ser_frame_i = 1'b1;
        tick(HALF);
        for (int i = 0; i < n - 1; i++) send_bit(frame_bits[i]);
        // Final bit: pop exactly in the cycle whose closing edge pushes it.
        ser_data_i = frame_bits[n - 1];
        tick(HALF);
        ser_clk_i = 1'b1;
        tick(SYNC);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        checks++; if (fifo_level !== 3'(DEPTH)) begin errors++; $display("FAIL fullpop_level got %0d want %0d", fifo_level, DEPTH); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got %0b want 0", overflow); end
        tick(HALF);
        ser_clk_i = 1'b0;
        tick(HALF);
        ser_frame_i = 1'b0;
        tick(2 * HALF);
        out_ready = 1'b1;
        for (int i = 0; i < 400 && out_valid; i++) tick(1);
        checks++; if (rcv_q.size() !== exp_q.size()) begin errors++; $display("FAIL fullpop_count got %0d want %0d", rcv_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL fullpop_word%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
        end
        $display("full_pop: words=%0d overflow=%0b", rcv_q.size(), overflow);
        rcv_q.delete(); exp_q.delete();
    endtask

`ifdef BEP_RX_PARITY_EN
    task automatic test_parity();
        int dropped;
        out_ready = 1'b1;
        frame_bits.delete();
        add_word(8'h0F, 1'b0);
        add_word(8'h3C, 1'b1);
        model_frame(1000, dropped);
        send_frame();
        for (int i = 0; i < 400 && out_valid; i++) tick(1);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_err got %0b want 1", parity_err); end
        checks++; if (rcv_q.size() !== exp_q.size()) begin errors++; $display("FAIL parity_count got %0d want %0d", rcv_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            checks++; if (rcv_q[i] !== exp_q[i]) begin errors++; $display("FAIL parity_word%0d got %h want %h", i, rcv_q[i], exp_q[i]); end
        end
        $display("parity: parity_err=%0b words=%0d", parity_err, rcv_q.size());
        rcv_q.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_three_words();
        test_random_frames();
        test_frame_err();
        test_overflow();
        test_reset_mid();
        test_full_pop();
`ifdef BEP_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bep_serial_rx.md
Name: bep_serial_rx

Overview:
- Front-end stage directly upstream of the BEP decode core inside the TinyTapeout project.
- Receives an externally clocked serial stream on dedicated input pins (serial clock, data, frame), synchronises it into clk, deserialises MSB-first into DATA_W-bit words and buffers them in a small FIFO.
- Presents words to the decoder over a valid/ready interface, with frame-boundary marking and error flags.

Parameters:
- DATA_W, 8, word width in bits; legal range 4..16.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, synchroniser flops per serial input; at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ser_clk_i  in  1  external serial clock (asynchronous, from ui_in); data sampled on its rising edge.
- ser_data_i  in  1  external serial data (asynchronous).
- ser_frame_i  in  1  external frame enable (asynchronous), active high.
- out_data  out  DATA_W  word at FIFO head.
- out_first  out  1  head word is the first word of its frame.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  decoder accepts the head word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: frame ended with a partial word.

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs 0 (out_data 0, fifo_level 0).
  - FIFO emptied; bit counter, shift register, synchronisers and sticky flags cleared.
  - FSM to IDLE.
  - Applies equally mid-word or mid-frame; an in-progress word is discarded.
- Synchronisation:
  - Each serial input passes through SYNC_STAGES flops.
  - Serial-clock rising edge detected in cycle N when the synchronised ser_clk is 1 and its one-cycle-delayed copy is 0.
  - Pin-to-detect latency is SYNC_STAGES+1 clk cycles.
  - ser_clk must stay high and low for at least 3 clk cycles each; faster input is out of contract.
- FSM states:
  - IDLE: waits for a rising edge of synchronised frame; on it, goes to SHIFT, clears the bit count, sets first_pending=1.
  - SHIFT: on each detected ser_clk edge, shifts synchronised data in MSB-first and increments the bit count.
    - When the count reaches DATA_W, the word is pushed on the same clk edge, the count resets to 0 and first_pending clears.
    - out_first of the pushed word equals first_pending.
    - On frame falling edge: returns to IDLE; if count != 0, frame_err pulses for exactly one cycle and the partial bits are discarded.
  - ser_clk edges outside SHIFT are ignored.
- Push/valid timing:
  - A word completed at a detect in cycle N is written at the end of cycle N.
  - out_valid rises in cycle N+1 if the FIFO was empty; no bypass path.
- Pop: a transfer occurs on any clk edge where out_valid and out_ready are both high; the head advances.
- FIFO:
  - Circular buffer with read and write pointers one bit wider than the address; full and empty derived from the pointers.
  - Push and pop in the same cycle on a full FIFO: both succeed, level unchanged, no overflow.
  - Push and pop in the same cycle on an empty FIFO: the push succeeds, nothing is popped, level becomes 1.
  - Push while full with no pop: word dropped, overflow set and held until reset.
- Simultaneous frame falling edge and final-bit ser_clk edge in the same cycle: the bit is shifted, the word is pushed, then IDLE with no frame_err.
- out_data and out_first are valid only while out_valid is high; both hold stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro BEP_RX_PARITY_EN.
- Defined:
  - Each word is followed by one odd-parity bit; the FSM adds state PARITY after SHIFT completes DATA_W bits.
  - Word pushed only if parity matches.
  - On mismatch: word dropped; new output parity_err (1 bit, sticky until reset) is set; FSM returns to SHIFT.
  - A frame ending in PARITY also pulses frame_err.
- Undefined: no parity bit, no PARITY state, no parity_err port.

Decomposition:
- Package bep_rx_pkg:
  - FSM state enum (IDLE, SHIFT, PARITY).
  - Default DATA_W and FIFO_DEPTH constants.
  - Function computing odd parity of a DATA_W vector.
- One natural sub-module: bep_rx_fifo.
  - Parameterised synchronous FIFO carrying {first, data}, DATA_W+1 bits wide.
  - Provides push, pop, full, empty and level outputs.
- Synchronisers, edge detect and FSM stay in bep_serial_rx.

Test Plan:
- Reset, then frame high and 8 bits 0xA5 MSB-first with out_ready=1 -> one transfer, out_data=0xA5, out_first=1, overflow=0, frame_err=0.
- Frame of 3 words 0x12, 0x34, 0x56 -> out_first=1,0,0 in order; fifo_level returns to 0.
- out_ready=0, send 5 words with FIFO_DEPTH=4 -> fifo_level=4, overflow=1; draining yields only the first 4 words.
- FIFO full, final bit of a new word arrives in the same cycle as a pop -> fifo_level stays 4, overflow stays 0.
- Frame dropped after 3 bits -> single-cycle frame_err, no push; next frame's first word has out_first=1.
- rst asserted mid-word with 2 words queued -> out_valid=0, fifo_level=0, overflow=0 the cycle after; a following clean frame decodes correctly.
- With BEP_RX_PARITY_EN defined: send 0x0F with parity bit 0 -> word dropped, parity_err=1.
